mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single off-chip memory port between the I-cache miss path and the D-cache miss/write-back path of the pipelined RISC-V core.
- Sits below both caches; each cache's memory-side request port connects here.
- Serialises transactions with a 4-state FSM and applies fixed or round-robin priority.
- Registers the memory read data and returns a one-cycle ready pulse to the granted cache.

Parameters:
ADDR_W, 28, block address width (word address >> 2)
DATA_W, 128, memory block width
ARB_MODE, 1, 0 = D-cache fixed priority, 1 = round-robin on simultaneous requests
CNT_W, 16, width of grant performance counters

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
ic_mem_read  in  1  I-cache block read request, level, held until ic_mem_ready
ic_mem_addr  in  ADDR_W  I-cache block address
ic_mem_ready  out  1  one-cycle pulse, ic_mem_rdata valid
ic_mem_rdata  out  DATA_W  read block to I-cache
dc_mem_read  in  1  D-cache read request, level
dc_mem_write  in  1  D-cache write-back request, level
dc_mem_addr  in  ADDR_W  D-cache block address
dc_mem_wdata  in  DATA_W  D-cache write-back block
dc_mem_ready  out  1  one-cycle pulse, write done / dc_mem_rdata valid
dc_mem_rdata  out  DATA_W  read block to D-cache
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory completion, single-cycle pulse
mem_rdata  in  DATA_W  memory read data, valid with mem_ready
ic_grant_cnt  out  CNT_W  completed I-cache transactions, wraps
dc_grant_cnt  out  CNT_W  completed D-cache transactions, wraps

Behaviour:
- Reset values:
  - state = IDLE, last_grant = I.
  - All outputs 0, including both counters and both rdata registers.
- FSM states: IDLE, GRANT_I, GRANT_D, DONE. All outputs are registered.
- IDLE:
  - Only I request: latch owner = I, mem_addr <= ic_mem_addr, go GRANT_I.
  - Only D request: latch owner = D, mem_addr <= dc_mem_addr, mem_wdata <= dc_mem_wdata, go GRANT_D.
  - Both request:
    - ARB_MODE = 0: D wins.
    - ARB_MODE = 1: the requester not equal to last_grant wins. After reset, the first tie goes to D.
  - No request: stay IDLE.
- GRANT_x:
  - mem_read/mem_write are driven from the latched op.
  - mem_addr/mem_wdata are held constant for the whole transaction.
  - Requester inputs are ignored.
  - On mem_ready = 1:
    - Capture mem_rdata into the owner's rdata register.
    - Set owner's ready = 1 for the next cycle.
    - Clear mem_read/mem_write.
    - Increment owner's grant counter; it wraps at 2^CNT_W.
    - last_grant <= owner; go DONE.
- DONE:
  - Owner ready is high for exactly this cycle, then cleared.
  - Go IDLE unconditionally.
  - The requester must drop its request by the following IDLE cycle.
- D op select: dc_mem_write = 1 issues mem_write only, even if dc_mem_read is also 1. The cache re-issues the read afterwards as a separate transaction.
- Latency:
  - Request seen in IDLE at cycle t → mem strobe at t+1.
  - mem_ready at cycle k → ready pulse and data at k+1 → IDLE at k+2.
  - Next strobe is at k+3 at the earliest.
- rdata registers hold their value until the next completion for that same requester.
- mem_ready in IDLE or DONE is ignored; no state change, no counter change.
- mem_read and mem_write are never both 1. ic_mem_ready and dc_mem_ready are never both 1.
- Reset mid-transaction:
  - Return to IDLE, all strobes and ready outputs cleared on the next edge.
  - Any in-flight mem_ready is dropped.
  - Counters reset.
- No timeout: GRANT_x waits indefinitely for mem_ready.

Test Plan:
- Single I read: ic_mem_read = 1, addr 0x0000040. Memory answers with mem_ready after 4 cycles, rdata 0xDEADBEEF_…_0001 → mem_read = 1 with mem_addr 0x0000040 on the cycle after the request. ic_mem_ready pulses 1 cycle with matching data. ic_grant_cnt = 1.
- D write-back: dc_mem_write = 1, addr 0x0000100, wdata 0x1111…1111 → mem_write = 1 with held addr/wdata, mem_read = 0. dc_mem_ready pulses once. ic_mem_ready stays 0.
- Tie in round-robin: both request continuously after reset → grant order D, I, D, I over 4 transactions. Counters end at 2 and 2. With ARB_MODE = 0 → D is served every time I and D tie.
- Read+write both asserted on D: dc_mem_read = dc_mem_write = 1 → mem_write only. Then dc_mem_write drops, dc_mem_read stays 1 → a separate mem_read transaction follows.
- Spurious mem_ready in IDLE → no ready pulse, counters unchanged, state stays IDLE.
- Reset asserted 2 cycles into GRANT_I: mem_read = 0 on the next edge. A later mem_ready is ignored. The arbiter accepts a new request afterwards with normal latency.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-way arbiter (I-cache / D-cache) onto one memory port; strobe 1 cycle after request, ready pulse 1 cycle after mem_ready.
// No backpressure beyond request levels: a granted transaction waits indefinitely for mem_ready, then returns through DONE to IDLE.
module mem_arbiter #(
  parameter int ADDR_W   = 28,
  parameter int DATA_W   = 128,
  parameter int ARB_MODE = 1,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_mem_read,
  input  logic [ADDR_W-1:0] ic_mem_addr,
  output logic              ic_mem_ready,
  output logic [DATA_W-1:0] ic_mem_rdata,
  input  logic              dc_mem_read,
  input  logic              dc_mem_write,
  input  logic [ADDR_W-1:0] dc_mem_addr,
  input  logic [DATA_W-1:0] dc_mem_wdata,
  output logic              dc_mem_ready,
  output logic [DATA_W-1:0] dc_mem_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  ic_grant_cnt,
  output logic [CNT_W-1:0]  dc_grant_cnt
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, DONE} state_t;

  localparam bit RR = (ARB_MODE != 0);

  state_t            r_state;
  logic              r_last_d;
  logic              r_mem_read;
  logic              r_mem_write;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_ic_ready;
  logic              r_dc_ready;
  logic [DATA_W-1:0] r_ic_rdata;
  logic [DATA_W-1:0] r_dc_rdata;
  logic [CNT_W-1:0]  r_ic_cnt;
  logic [CNT_W-1:0]  r_dc_cnt;

  logic w_i_req;
  logic w_d_req;
  logic w_pick_d;

  assign w_i_req = ic_mem_read;
  assign w_d_req = dc_mem_read | dc_mem_write;
  // On a tie, round-robin hands the port to whoever was not served last.
  assign w_pick_d = w_d_req && (!w_i_req || !RR || !r_last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_d    <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_ic_ready  <= 1'b0;
      r_dc_ready  <= 1'b0;
      r_ic_rdata  <= '0;
      r_dc_rdata  <= '0;
      r_ic_cnt    <= '0;
      r_dc_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick_d) begin
            r_state     <= GRANT_D;
            r_mem_addr  <= dc_mem_addr;
            r_mem_wdata <= dc_mem_wdata;
            // A write-back takes precedence; the read is re-issued later by the cache.
            r_mem_write <= dc_mem_write;
            r_mem_read  <= !dc_mem_write;
          end else if (w_i_req) begin
            r_state     <= GRANT_I;
            r_mem_addr  <= ic_mem_addr;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
          end
        end
        GRANT_I: begin
          if (mem_ready) begin
            r_ic_rdata  <= mem_rdata;
            r_ic_ready  <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_ic_cnt    <= r_ic_cnt + CNT_W'(1);
            r_last_d    <= 1'b0;
            r_state     <= DONE;
          end
        end
        GRANT_D: begin
          if (mem_ready) begin
            r_dc_rdata  <= mem_rdata;
            r_dc_ready  <= 1'b1;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_dc_cnt    <= r_dc_cnt + CNT_W'(1);
            r_last_d    <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_ic_ready <= 1'b0;
          r_dc_ready <= 1'b0;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_read     = r_mem_read;
  assign mem_write    = r_mem_write;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign ic_mem_ready = r_ic_ready;
  assign dc_mem_ready = r_dc_ready;
  assign ic_mem_rdata = r_ic_rdata;
  assign dc_mem_rdata = r_dc_rdata;
  assign ic_grant_cnt = r_ic_cnt;
  assign dc_grant_cnt = r_dc_cnt;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: round-robin instance driven by a memory responder, plus a fixed-priority instance in lockstep.
module tb_mem_arbiter;

  logic         clk;
  logic         rst;
  logic         ic_mem_read;
  logic [27:0]  ic_mem_addr;
  logic         dc_mem_read;
  logic         dc_mem_write;
  logic [27:0]  dc_mem_addr;
  logic [127:0] dc_mem_wdata;
  logic         mem_ready;
  logic [127:0] mem_rdata;

  logic         ic_mem_ready, dc_mem_ready, mem_read, mem_write;
  logic [127:0] ic_mem_rdata, dc_mem_rdata, mem_wdata;
  logic [27:0]  mem_addr;
  logic [15:0]  ic_grant_cnt, dc_grant_cnt;

  logic         f_ic_ready, f_dc_ready, f_mem_read, f_mem_write;
  logic [127:0] f_ic_rdata, f_dc_rdata, f_mem_wdata;
  logic [27:0]  f_mem_addr;
  logic [15:0]  f_ic_cnt, f_dc_cnt;

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .ARB_MODE(1), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
    .ic_mem_ready(ic_mem_ready), .ic_mem_rdata(ic_mem_rdata),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
    .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
    .dc_mem_ready(dc_mem_ready), .dc_mem_rdata(dc_mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ic_grant_cnt(ic_grant_cnt), .dc_grant_cnt(dc_grant_cnt)
  );

  mem_arbiter #(.ADDR_W(28), .DATA_W(128), .ARB_MODE(0), .CNT_W(16)) u_fix (
    .clk(clk), .rst(rst),
    .ic_mem_read(ic_mem_read), .ic_mem_addr(ic_mem_addr),
    .ic_mem_ready(f_ic_ready), .ic_mem_rdata(f_ic_rdata),
    .dc_mem_read(dc_mem_read), .dc_mem_write(dc_mem_write),
    .dc_mem_addr(dc_mem_addr), .dc_mem_wdata(dc_mem_wdata),
    .dc_mem_ready(f_dc_ready), .dc_mem_rdata(f_dc_rdata),
    .mem_read(f_mem_read), .mem_write(f_mem_write), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .ic_grant_cnt(f_ic_cnt), .dc_grant_cnt(f_dc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference state: who was served last (0 = I, 1 = D), counts and last returned blocks.
  int           last_owner;
  int           exp_ic, exp_dc;
  logic [127:0] exp_ic_dat, exp_dc_dat;

  // Observations returned by the memory responder.
  int           o_wc;
  logic         o_rd, o_wr, o_clr, o_ir, o_dr, o_fir, o_fdr;
  logic [27:0]  o_addr;
  logic [127:0] o_wd, o_idat, o_ddat;
  bit           o_held;

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    last_owner = 0;
    exp_ic = 0;
    exp_dc = 0;
    exp_ic_dat = '0;
    exp_dc_dat = '0;
  endtask

  // Memory side: wait for a strobe, hold for lat cycles, answer, then sample the ready pulse.
  task automatic mem_respond(input int lat, input logic [127:0] rd, input bit perturb);
    o_wc = -1; o_held = 1'b1; o_rd = 0; o_wr = 0; o_addr = '0; o_wd = '0;
    o_ir = 0; o_dr = 0; o_fir = 0; o_fdr = 0; o_idat = '0; o_ddat = '0; o_clr = 0;
    for (int c = 1; c <= 20 && o_wc < 0; c++) begin
      @(negedge clk);
      if (mem_read || mem_write) o_wc = c;
    end
    if (o_wc < 0) return;
    o_rd = mem_read; o_wr = mem_write; o_addr = mem_addr; o_wd = mem_wdata;
    if (mem_read && mem_write) o_held = 1'b0;
    for (int c = 1; c < lat; c++) begin
      if (perturb) begin
        ic_mem_addr  = 28'($urandom());
        dc_mem_addr  = 28'($urandom());
        dc_mem_wdata = rnd128();
      end
      @(negedge clk);
      if ({mem_read, mem_write, mem_addr, mem_wdata} !== {o_rd, o_wr, o_addr, o_wd} ||
          ic_mem_ready || dc_mem_ready) o_held = 1'b0;
    end
    mem_rdata = rd;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    mem_rdata = rnd128();
    o_ir = ic_mem_ready; o_dr = dc_mem_ready; o_fir = f_ic_ready; o_fdr = f_dc_ready;
    o_idat = ic_mem_rdata; o_ddat = dc_mem_rdata;
    o_clr = !(mem_read || mem_write);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({mem_read, mem_write, ic_mem_ready, dc_mem_ready} !== 4'b0) begin
      bad++; $display("FAIL reset_strobes got=%b want=0000", {mem_read, mem_write, ic_mem_ready, dc_mem_ready}); end
    total++; if ({mem_addr, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_addr_wdata got=%h/%h want=0", mem_addr, mem_wdata); end
    total++; if ({ic_mem_rdata, dc_mem_rdata} !== '0) begin
      bad++; $display("FAIL reset_rdata got=%h/%h want=0", ic_mem_rdata, dc_mem_rdata); end
    total++; if ({ic_grant_cnt, dc_grant_cnt, f_ic_cnt, f_dc_cnt} !== '0) begin
      bad++; $display("FAIL reset_counters got=%h want=0", {ic_grant_cnt, dc_grant_cnt, f_ic_cnt, f_dc_cnt}); end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_single_i();
    logic [127:0] rd;
    rd = 128'hDEADBEEF_00000000_00000000_00000001;
    ic_mem_addr = 28'h0000040;
    ic_mem_read = 1'b1;
    mem_respond(4, rd, 1'b0);
    ic_mem_read = 1'b0;
    exp_ic++; exp_ic_dat = rd; last_owner = 0;
    total++; if (o_wc !== 1) begin bad++; $display("FAIL single_i_latency got=%0d want=1", o_wc); end
    total++; if ({o_rd, o_wr} !== 2'b10) begin bad++; $display("FAIL single_i_op got=%b want=10", {o_rd, o_wr}); end
    total++; if (o_addr !== 28'h0000040) begin bad++; $display("FAIL single_i_addr got=%h want=0000040", o_addr); end
    total++; if (!o_held) begin bad++; $display("FAIL single_i_hold got=changed want=stable"); end
    total++; if ({o_ir, o_dr, o_clr} !== 3'b101) begin bad++; $display("FAIL single_i_ready got=%b want=101", {o_ir, o_dr, o_clr}); end
    total++; if (o_idat !== rd) begin bad++; $display("FAIL single_i_data got=%h want=%h", o_idat, rd); end
    @(negedge clk);
    total++; if (ic_mem_ready !== 1'b0) begin bad++; $display("FAIL single_i_pulse_len got=%b want=0", ic_mem_ready); end
    total++; if (ic_grant_cnt !== 16'(exp_ic)) begin bad++; $display("FAIL single_i_cnt got=%0d want=%0d", ic_grant_cnt, exp_ic); end
  endtask

  task automatic test_d_write();
    logic [127:0] rd, wd;
    rd = rnd128();
    wd = {32{4'h1}};
    dc_mem_addr = 28'h0000100; dc_mem_wdata = wd; dc_mem_write = 1'b1;
    mem_respond(3, rd, 1'b0);
    dc_mem_write = 1'b0;
    exp_dc++; exp_dc_dat = rd; last_owner = 1;
    total++; if (o_wc !== 1) begin bad++; $display("FAIL d_write_latency got=%0d want=1", o_wc); end
    total++; if ({o_rd, o_wr} !== 2'b01) begin bad++; $display("FAIL d_write_op got=%b want=01", {o_rd, o_wr}); end
    total++; if ({o_addr, o_wd} !== {28'h0000100, wd}) begin bad++; $display("FAIL d_write_addr_data got=%h/%h want=0000100/%h", o_addr, o_wd, wd); end
    total++; if (!o_held) begin bad++; $display("FAIL d_write_hold got=changed want=stable"); end
    total++; if ({o_ir, o_dr} !== 2'b01) begin bad++; $display("FAIL d_write_ready got=%b want=01", {o_ir, o_dr}); end
    @(negedge clk);
    total++; if ({ic_mem_ready, dc_mem_ready} !== 2'b00) begin bad++; $display("FAIL d_write_pulse_len got=%b want=00", {ic_mem_ready, dc_mem_ready}); end
    total++; if ({ic_grant_cnt, dc_grant_cnt} !== {16'(exp_ic), 16'(exp_dc)}) begin
      bad++; $display("FAIL d_write_cnt got=%0d/%0d want=%0d/%0d", ic_grant_cnt, dc_grant_cnt, exp_ic, exp_dc); end
  endtask

  task automatic test_rr_tie();
    logic [127:0] rd;
    int want_d;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    ic_mem_addr = 28'h0000A00; dc_mem_addr = 28'h0000B00; dc_mem_wdata = rnd128();
    ic_mem_read = 1'b1; dc_mem_read = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd = rnd128();
      mem_respond(2, rd, 1'b0);
      want_d = (last_owner == 1) ? 0 : 1;
      last_owner = want_d;
      if (want_d == 1) begin exp_dc++; exp_dc_dat = rd; end
      else begin exp_ic++; exp_ic_dat = rd; end
      total++; if ({o_ir, o_dr} !== ((want_d == 1) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL rr_tie_order[%0d] got=%b want_d=%0d", k, {o_ir, o_dr}, want_d); end
      total++; if ({o_fir, o_fdr} !== 2'b01) begin
        bad++; $display("FAIL fixed_tie_order[%0d] got=%b want=01", k, {o_fir, o_fdr}); end
      total++; if (o_addr !== ((want_d == 1) ? 28'h0000B00 : 28'h0000A00)) begin
        bad++; $display("FAIL rr_tie_addr[%0d] got=%h", k, o_addr); end
    end
    ic_mem_read = 1'b0; dc_mem_read = 1'b0;
    @(negedge clk);
    total++; if ({ic_grant_cnt, dc_grant_cnt} !== {16'd2, 16'd2}) begin
      bad++; $display("FAIL rr_tie_cnt got=%0d/%0d want=2/2", ic_grant_cnt, dc_grant_cnt); end
    total++; if ({f_ic_cnt, f_dc_cnt} !== {16'd0, 16'd4}) begin
      bad++; $display("FAIL fixed_tie_cnt got=%0d/%0d want=0/4", f_ic_cnt, f_dc_cnt); end
    total++; if ({ic_mem_rdata, dc_mem_rdata} !== {exp_ic_dat, exp_dc_dat}) begin
      bad++; $display("FAIL rr_tie_rdata got=%h/%h want=%h/%h", ic_mem_rdata, dc_mem_rdata, exp_ic_dat, exp_dc_dat); end
  endtask

  task automatic test_rw_both();
    logic [127:0] rd1, rd2, wd;
    rd1 = rnd128(); rd2 = rnd128(); wd = rnd128();
    dc_mem_addr = 28'h0123456; dc_mem_wdata = wd;
    dc_mem_read = 1'b1; dc_mem_write = 1'b1;
    mem_respond(2, rd1, 1'b0);
    dc_mem_write = 1'b0;
    exp_dc++; exp_dc_dat = rd1; last_owner = 1;
    total++; if ({o_rd, o_wr} !== 2'b01) begin bad++; $display("FAIL rw_both_op got=%b want=01", {o_rd, o_wr}); end
    total++; if (o_wd !== wd) begin bad++; $display("FAIL rw_both_wdata got=%h want=%h", o_wd, wd); end
    total++; if (o_dr !== 1'b1) begin bad++; $display("FAIL rw_both_ready got=%b want=1", o_dr); end
    mem_respond(3, rd2, 1'b0);
    dc_mem_read = 1'b0;
    exp_dc++; exp_dc_dat = rd2;
    total++; if (o_wc !== 2) begin bad++; $display("FAIL rw_reissue_latency got=%0d want=2", o_wc); end
    total++; if ({o_rd, o_wr, o_addr} !== {2'b10, 28'h0123456}) begin
      bad++; $display("FAIL rw_reissue_op got=%b addr=%h want=10/0123456", {o_rd, o_wr}, o_addr); end
    total++; if ({o_dr, o_ddat} !== {1'b1, rd2}) begin bad++; $display("FAIL rw_reissue_data got=%b/%h want=1/%h", o_dr, o_ddat, rd2); end
    @(negedge clk);
    total++; if (dc_grant_cnt !== 16'(exp_dc)) begin bad++; $display("FAIL rw_cnt got=%0d want=%0d", dc_grant_cnt, exp_dc); end
  endtask

  task automatic test_spurious();
    logic [127:0] rd;
    mem_rdata = rnd128();
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    total++; if ({ic_mem_ready, dc_mem_ready, mem_read, mem_write} !== 4'b0) begin
      bad++; $display("FAIL spurious_outputs got=%b want=0000", {ic_mem_ready, dc_mem_ready, mem_read, mem_write}); end
    total++; if ({ic_grant_cnt, dc_grant_cnt} !== {16'(exp_ic), 16'(exp_dc)}) begin
      bad++; $display("FAIL spurious_cnt got=%0d/%0d want=%0d/%0d", ic_grant_cnt, dc_grant_cnt, exp_ic, exp_dc); end
    total++; if ({ic_mem_rdata, dc_mem_rdata} !== {exp_ic_dat, exp_dc_dat}) begin
      bad++; $display("FAIL spurious_rdata got=%h/%h", ic_mem_rdata, dc_mem_rdata); end
    @(negedge clk);
    rd = rnd128();
    ic_mem_addr = 28'h0FFFFFF; ic_mem_read = 1'b1;
    mem_respond(1, rd, 1'b0);
    ic_mem_read = 1'b0;
    exp_ic++; exp_ic_dat = rd; last_owner = 0;
    total++; if ({o_wc, o_rd, o_addr} !== {32'sd1, 1'b1, 28'h0FFFFFF}) begin
      bad++; $display("FAIL spurious_then_req got=lat%0d rd%b addr%h want=lat1 rd1 addr0FFFFFF", o_wc, o_rd, o_addr); end
    total++; if ({o_ir, o_idat} !== {1'b1, rd}) begin bad++; $display("FAIL spurious_then_data got=%b/%h want=1/%h", o_ir, o_idat, rd); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [127:0] rd;
    ic_mem_addr = 28'h0000555; ic_mem_read = 1'b1;
    for (int c = 0; c < 20 && !mem_read; c++) @(negedge clk);
    total++; if (mem_read !== 1'b1) begin bad++; $display("FAIL reset_mid_grant got=%b want=1", mem_read); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; ic_mem_read = 1'b0;
    model_reset();
    total++; if ({mem_read, mem_write, ic_mem_ready, dc_mem_ready} !== 4'b0) begin
      bad++; $display("FAIL reset_mid_strobes got=%b want=0000", {mem_read, mem_write, ic_mem_ready, dc_mem_ready}); end
    total++; if ({ic_grant_cnt, dc_grant_cnt} !== 32'd0) begin
      bad++; $display("FAIL reset_mid_cnt got=%0d/%0d want=0/0", ic_grant_cnt, dc_grant_cnt); end
    mem_rdata = rnd128(); mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    @(negedge clk);
    total++; if ({ic_mem_ready, dc_mem_ready, ic_grant_cnt, dc_grant_cnt, ic_mem_rdata} !== '0) begin
      bad++; $display("FAIL reset_mid_late_ready got=%b/%0d/%h want=0", ic_mem_ready, ic_grant_cnt, ic_mem_rdata); end
    rd = rnd128();
    ic_mem_addr = 28'h0000777; ic_mem_read = 1'b1;
    mem_respond(2, rd, 1'b0);
    ic_mem_read = 1'b0;
    exp_ic = 1; exp_ic_dat = rd; last_owner = 0;
    total++; if ({o_wc, o_rd, o_addr} !== {32'sd1, 1'b1, 28'h0000777}) begin
      bad++; $display("FAIL reset_mid_new_req got=lat%0d rd%b addr%h want=lat1 rd1 addr0000777", o_wc, o_rd, o_addr); end
    @(negedge clk);
    total++; if (ic_grant_cnt !== 16'd1) begin bad++; $display("FAIL reset_mid_new_cnt got=%0d want=1", ic_grant_cnt); end
  endtask

  task automatic test_random();
    bit ireq, drd, dwr;
    int want_d, lat;
    logic [27:0]  ia, da;
    logic [127:0] wd, rd;
    for (int it = 0; it < 40; it++) begin
      ireq = 1'($urandom_range(0, 1)); drd = 1'($urandom_range(0, 1)); dwr = 1'($urandom_range(0, 1));
      if (!ireq && !drd && !dwr) ireq = 1'b1;
      ia = 28'($urandom()); da = 28'($urandom()); wd = rnd128(); rd = rnd128();
      lat = $urandom_range(1, 5);
      ic_mem_addr = ia; dc_mem_addr = da; dc_mem_wdata = wd;
      ic_mem_read = ireq; dc_mem_read = drd; dc_mem_write = dwr;
      if (ireq && (drd || dwr)) want_d = (last_owner == 1) ? 0 : 1;
      else want_d = (drd || dwr) ? 1 : 0;
      mem_respond(lat, rd, 1'b1);
      ic_mem_read = 1'b0; dc_mem_read = 1'b0; dc_mem_write = 1'b0;
      last_owner = want_d;
      if (want_d == 1) begin exp_dc++; exp_dc_dat = rd; end
      else begin exp_ic++; exp_ic_dat = rd; end
      total++; if (o_wc !== 1 || !o_held) begin bad++; $display("FAIL rand[%0d]_lat_hold got=lat%0d held%0d", it, o_wc, o_held); end
      if (want_d == 1) begin
        total++; if ({o_rd, o_wr, o_addr} !== {!dwr, dwr, da}) begin
          bad++; $display("FAIL rand[%0d]_d_op got=%b/%h want=%b/%h", it, {o_rd, o_wr}, o_addr, {!dwr, dwr}, da); end
        if (dwr) begin
          total++; if (o_wd !== wd) begin bad++; $display("FAIL rand[%0d]_d_wdata got=%h want=%h", it, o_wd, wd); end
        end
      end else begin
        total++; if ({o_rd, o_wr, o_addr} !== {2'b10, ia}) begin
          bad++; $display("FAIL rand[%0d]_i_op got=%b/%h want=10/%h", it, {o_rd, o_wr}, o_addr, ia); end
      end
      total++; if ({o_ir, o_dr} !== ((want_d == 1) ? 2'b01 : 2'b10)) begin
        bad++; $display("FAIL rand[%0d]_winner got=%b want_d=%0d", it, {o_ir, o_dr}, want_d); end
      total++; if ({o_idat, o_ddat} !== {exp_ic_dat, exp_dc_dat}) begin
        bad++; $display("FAIL rand[%0d]_rdata got=%h/%h want=%h/%h", it, o_idat, o_ddat, exp_ic_dat, exp_dc_dat); end
      @(negedge clk);
      total++; if ({ic_mem_ready, dc_mem_ready, ic_grant_cnt, dc_grant_cnt} !== {2'b00, 16'(exp_ic), 16'(exp_dc)}) begin
        bad++; $display("FAIL rand[%0d]_after got=%b %0d/%0d want=00 %0d/%0d", it,
                        {ic_mem_ready, dc_mem_ready}, ic_grant_cnt, dc_grant_cnt, exp_ic, exp_dc); end
    end
  endtask

  initial begin
    rst = 1'b1; ic_mem_read = 1'b0; ic_mem_addr = '0;
    dc_mem_read = 1'b0; dc_mem_write = 1'b0; dc_mem_addr = '0; dc_mem_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    model_reset();
    test_reset();
    test_single_i();
    test_d_write();
    test_rr_tie();
    test_rw_both();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
